// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the datapath / instruction register.
interface multicycle_controller_if #(
    parameter int unsigned OPW  = 7,
    parameter int unsigned SELW = 2
);
    logic [OPW-1:0]  IW2Contr;
    logic            mem_ready;

    logic            LIR;
    logic            LPC;
    logic            rd1;
    logic            rd2;
    logic            wr_contr;
    logic            isJumpInstr;
    logic            isCallInstr;
    logic            Lflag_contr;
    logic            rdM;
    logic            wrM_contr;
    logic [SELW-1:0] selM1;
    logic [SELW-1:0] selM2;
    logic [SELW-1:0] selM3;
    logic [SELW-1:0] fnSel;
    logic            illegal;
    logic            mem_err;

    // Controller side
    modport master (
        input  IW2Contr, mem_ready,
        output LIR, LPC, rd1, rd2, wr_contr, isJumpInstr, isCallInstr, Lflag_contr,
               rdM, wrM_contr, selM1, selM2, selM3, fnSel, illegal, mem_err
    );

    // Datapath side
    modport slave (
        output IW2Contr, mem_ready,
        input  LIR, LPC, rd1, rd2, wr_contr, isJumpInstr, isCallInstr, Lflag_contr,
               rdM, wrM_contr, selM1, selM2, selM3, fnSel, illegal, mem_err
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with registered
// datapath controls, memory ready handshake and a MEM-state timeout.
module multicycle_controller #(
    parameter int unsigned OPW       = 7,
    parameter int unsigned SELW      = 2,
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rstIn,
    multicycle_controller_if.master ctrl
);

    localparam int unsigned OPF  = 7;
    localparam int unsigned CNTW = (TO_CYCLES == 0) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TO_CYCLES == 0) ? 0 : TO_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(TO_CYCLES);

    // Select codes: bit 2 marks a listed value, bits 1:0 the value itself.
    localparam logic [2:0] S00 = 3'b100;
    localparam logic [2:0] S01 = 3'b101;
    localparam logic [2:0] S10 = 3'b110;
    localparam logic [2:0] S11 = 3'b111;
    localparam logic [2:0] SNA = 3'b000;

    // S_RESET is held only while rstIn is high, so that the registered LIR of
    // FETCH is visible in the first cycle after reset is released.
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic       rd1;
        logic       rd2;
        logic       wr;
        logic       lflag;
        logic       jump;
        logic       call;
        logic       rdm;
        logic       wrm;
        logic       illegal;
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] m3;
        logic [2:0] fn;
    } dec_t;

    typedef struct packed {
        logic            lir;
        logic            lpc;
        logic            rd1;
        logic            rd2;
        logic            wr;
        logic            jump;
        logic            call;
        logic            lflag;
        logic            rdm;
        logic            wrm;
        logic            illegal;
        logic            mem_err;
        logic [SELW-1:0] m1;
        logic [SELW-1:0] m2;
        logic [SELW-1:0] m3;
        logic [SELW-1:0] fn;
    } ctl_t;

    state_e          state_q, state_d;
    logic [OPF-1:0]  op_q, op_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    ctl_t            ctl_q, ctl_d;
    dec_t            dec_c;
    logic            timeout_c;

    // Listed codes are zero-extended, unlisted ones become all ones.
    function automatic logic [SELW-1:0] to_sel(input logic [2:0] c);
        return c[2] ? SELW'(c[1:0]) : '1;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t c;
        c    = '0;
        c.m1 = '1;
        c.m2 = '1;
        c.m3 = '1;
        c.fn = '1;
        return c;
    endfunction

    // Opcode class decode.
    function automatic dec_t decode(input logic [OPF-1:0] op);
        dec_t d;
        d    = '0;
        d.m1 = SNA;
        d.m2 = SNA;
        d.m3 = SNA;
        d.fn = SNA;
        if (!op[6]) begin
            if (!op[5]) begin
                // ALUi / ALUr
                d.rd1 = op[2];  d.rd2 = 1'b1;  d.wr = 1'b1;  d.lflag = 1'b1;
                d.m1 = op[2] ? S01 : S10;  d.m2 = S01;  d.m3 = S10;  d.fn = S00;
            end else if (!op[4]) begin
                if (!op[3]) begin
                    // mnsi / mnsr
                    d.rd1 = op[2];  d.rd2 = 1'b1;  d.lflag = 1'b1;
                    d.m1 = op[2] ? S01 : S10;  d.m2 = S01;  d.m3 = S10;  d.fn = S00;
                end else begin
                    // cmp
                    d.rd2 = 1'b1;  d.lflag = 1'b1;
                    d.m1 = S11;  d.m2 = S01;  d.m3 = S10;  d.fn = S01;
                end
            end else begin
                d.illegal = 1'b1;
            end
        end else begin
            case (op[5:4])
                2'b00: begin
                    case (op[2:1])
                        2'b00: begin
                            d.wr = 1'b1;
                            d.m2 = S10;  d.m3 = S10;  d.fn = S01;
                        end
                        2'b01: begin
                            d.rd1 = 1'b1;  d.wr = 1'b1;
                            d.m2 = S00;  d.m3 = S10;  d.fn = S01;
                        end
                        2'b10: begin
                            d.rd1 = 1'b1;  d.wr = 1'b1;  d.rdm = 1'b1;
                            d.m1 = S01;  d.m2 = S10;  d.m3 = S01;  d.fn = S10;
                        end
                        default: d.illegal = 1'b1;
                    endcase
                end
                2'b01: begin
                    d.rd1 = 1'b1;  d.rd2 = 1'b1;  d.wrm = 1'b1;
                    d.m1 = S01;  d.m2 = S10;  d.m3 = S11;  d.fn = S10;
                end
                2'b10: begin
                    d.jump = 1'b1;
                    d.m1 = S00;  d.m2 = S10;  d.m3 = S11;  d.fn = S10;
                end
                default: begin
                    if (!op[3]) begin
                        d.call = 1'b1;  d.wr = 1'b1;
                        d.m1 = S00;  d.m2 = S10;  d.m3 = S00;  d.fn = S10;
                    end else begin
                        d.call = 1'b1;  d.rd2 = 1'b1;
                        d.m2 = S01;  d.m3 = S11;  d.fn = S01;
                    end
                end
            endcase
        end
        return d;
    endfunction

    generate
        if (OPW > OPF) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^ctrl.IW2Contr[OPW-OPF-1:0];
        end
    endgenerate

    // Opcode is captured at the end of DECODE; decode looks at the value being captured.
    always_comb begin
        op_d  = (state_q == S_DECODE) ? ctrl.IW2Contr[OPW-1 -: OPF] : op_q;
        dec_c = decode(op_d);
    end

    // Timeout fires on the TO_CYCLES-th consecutive MEM cycle without mem_ready.
    always_comb begin
        timeout_c = (TO_CYCLES != 0) && (state_q == S_MEM) && !ctrl.mem_ready &&
                    (cnt_q == CNT_LAST);
        cnt_d = '0;
        if (state_q == S_MEM) begin
            cnt_d = cnt_q;
            if (!ctrl.mem_ready && (cnt_q != CNT_SAT)) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rstIn) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = dec_c.illegal ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (dec_c.rdm || dec_c.wrm) ? S_MEM : S_WB;
            S_MEM: begin
                if (ctrl.mem_ready) begin
                    state_d = S_WB;
                end else if (timeout_c) begin
                    state_d = S_HALT;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Output decode for the state being entered, so registered outputs line up with it.
    always_comb begin
        ctl_d         = idle_ctl();
        ctl_d.illegal = ctl_q.illegal | ((state_q == S_DECODE) && dec_c.illegal);
        ctl_d.mem_err = ctl_q.mem_err | timeout_c;
        ctl_d.lir     = (state_d == S_FETCH);
        if ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB)) begin
            ctl_d.rd1  = dec_c.rd1;
            ctl_d.rd2  = dec_c.rd2;
            ctl_d.jump = dec_c.jump;
            ctl_d.call = dec_c.call;
            ctl_d.m1   = to_sel(dec_c.m1);
            ctl_d.m2   = to_sel(dec_c.m2);
            ctl_d.m3   = to_sel(dec_c.m3);
            ctl_d.fn   = to_sel(dec_c.fn);
        end
        ctl_d.lflag = (state_d == S_EXEC) && dec_c.lflag;
        ctl_d.rdm   = (state_d == S_MEM) && dec_c.rdm;
        ctl_d.wrm   = (state_d == S_MEM) && dec_c.wrm;
        ctl_d.wr    = (state_d == S_WB) && dec_c.wr;
        ctl_d.lpc   = (state_d == S_WB);
    end

    // Opcode, wait counter and output registers.
    always_ff @(posedge clk) begin
        if (rstIn) begin
            op_q  <= '0;
            cnt_q <= '0;
            ctl_q <= idle_ctl();
        end else begin
            op_q  <= op_d;
            cnt_q <= cnt_d;
            ctl_q <= ctl_d;
        end
    end

    assign ctrl.LIR         = ctl_q.lir;
    assign ctrl.LPC         = ctl_q.lpc;
    assign ctrl.rd1         = ctl_q.rd1;
    assign ctrl.rd2         = ctl_q.rd2;
    assign ctrl.wr_contr    = ctl_q.wr;
    assign ctrl.isJumpInstr = ctl_q.jump;
    assign ctrl.isCallInstr = ctl_q.call;
    assign ctrl.Lflag_contr = ctl_q.lflag;
    assign ctrl.rdM         = ctl_q.rdm;
    assign ctrl.wrM_contr   = ctl_q.wrm;
    assign ctrl.selM1       = ctl_q.m1;
    assign ctrl.selM2       = ctl_q.m2;
    assign ctrl.selM3       = ctl_q.m3;
    assign ctrl.fnSel       = ctl_q.fn;
    assign ctrl.illegal     = ctl_q.illegal;
    assign ctrl.mem_err     = ctl_q.mem_err;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (OPW=7, SELW=2, TO_CYCLES=4).
module tb_multicycle_controller;

    logic clk;
    logic rstIn;
    int   errors;
    int   checks;

    multicycle_controller_if #(.OPW(7), .SELW(2)) bus ();

    multicycle_controller #(
        .OPW       (7),
        .SELW      (2),
        .TO_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rstIn (rstIn),
        .ctrl  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {LIR,LPC,rd1,rd2,wr,jump,call,lflag,rdM,wrM,illegal,mem_err}
    function automatic logic [11:0] ctl_bits();
        return {bus.LIR, bus.LPC, bus.rd1, bus.rd2, bus.wr_contr, bus.isJumpInstr,
                bus.isCallInstr, bus.Lflag_contr, bus.rdM, bus.wrM_contr,
                bus.illegal, bus.mem_err};
    endfunction

    function automatic logic [7:0] sel_bits();
        return {bus.selM1, bus.selM2, bus.selM3, bus.fnSel};
    endfunction

    logic lir_seen;

    initial begin
        errors        = 0;
        checks        = 0;
        rstIn         = 1'b1;
        bus.IW2Contr  = 7'b0000000;
        bus.mem_ready = 1'b0;
        lir_seen      = 1'b0;

        // Reset held three cycles
        step(); step(); step();
        chk("rst_ctl", 32'(ctl_bits()), 32'h000);
        chk("rst_sel", 32'(sel_bits()), 32'hFF);

        // addi 0000000
        rstIn = 1'b0;
        step();                                              // c0 FETCH
        chk("addi_c0_lir", 32'(bus.LIR), 1);
        chk("addi_c0_rd2", 32'(bus.rd2), 0);
        step();                                              // c1 DECODE
        chk("addi_c1_ctl", 32'(ctl_bits()), 32'h000);
        chk("addi_c1_m1", 32'(bus.selM1), 3);
        step();                                              // c2 EXEC
        chk("addi_c2_ctl", 32'(ctl_bits()), 32'h110);        // rd2, lflag
        chk("addi_c2_sel", 32'(sel_bits()), 32'h98);         // 10 01 10 00
        step();                                              // c3 WB
        chk("addi_c3_ctl", 32'(ctl_bits()), 32'h580);        // LPC, rd2, wr
        chk("addi_c3_m1", 32'(bus.selM1), 2);
        step();                                              // c4 FETCH
        chk("addi_c4_ctl", 32'(ctl_bits()), 32'h800);
        chk("addi_c4_sel", 32'(sel_bits()), 32'hFF);

        // la 1000100, ready low for 3 MEM cycles then high
        bus.IW2Contr = 7'b1000100;
        step();                                              // c5 DECODE
        chk("la_dec_rdm", 32'(bus.rdM), 0);
        step();                                              // c6 EXEC
        chk("la_exec_ctl", 32'(ctl_bits()), 32'h200);        // rd1 only
        chk("la_exec_sel", 32'(sel_bits()), 32'h66);         // 01 10 01 10
        step();                                              // c7 MEM
        chk("la_mem1_rdm", 32'(bus.rdM), 1);
        step();                                              // c8 MEM
        chk("la_mem2_rdm", 32'(bus.rdM), 1);
        step();                                              // c9 MEM
        chk("la_mem3_rdm", 32'(bus.rdM), 1);
        step();                                              // c10 MEM, ready now
        chk("la_mem4_rdm", 32'(bus.rdM), 1);
        bus.mem_ready = 1'b1;
        step();                                              // c11 WB
        bus.mem_ready = 1'b0;
        chk("la_wb_ctl", 32'(ctl_bits()), 32'h680);          // LPC, rd1, wr
        chk("la_wb_m3", 32'(bus.selM3), 1);
        step();                                              // c12 FETCH
        chk("la_next_lir", 32'(bus.LIR), 1);

        // mnsr 0100100
        bus.IW2Contr = 7'b0100100;
        step();                                              // DECODE
        step();                                              // EXEC
        chk("mnsr_exec_ctl", 32'(ctl_bits()), 32'h310);      // rd1, rd2, lflag
        step();                                              // WB
        chk("mnsr_wb_ctl", 32'(ctl_bits()), 32'h700);        // LPC, rd1, rd2
        step();                                              // FETCH
        chk("mnsr_next_lir", 32'(bus.LIR), 1);

        // cmp 0101000
        bus.IW2Contr = 7'b0101000;
        step();                                              // DECODE
        step();                                              // EXEC
        chk("cmp_exec_ctl", 32'(ctl_bits()), 32'h110);       // rd2, lflag
        chk("cmp_exec_sel", 32'(sel_bits()), 32'hD9);        // 11 01 10 01
        step();                                              // WB
        chk("cmp_wb_ctl", 32'(ctl_bits()), 32'h500);         // LPC, rd2
        chk("cmp_wb_fn", 32'(bus.fnSel), 1);
        step();                                              // FETCH

        // sta 1010000 with mem_ready low throughout -> timeout after 4 MEM cycles
        bus.IW2Contr = 7'b1010000;
        step();                                              // DECODE
        step();                                              // EXEC
        chk("sta_exec_ctl", 32'(ctl_bits()), 32'h300);       // rd1, rd2
        chk("sta_exec_sel", 32'(sel_bits()), 32'h6E);        // 01 10 11 10
        step();
        chk("sta_mem1_ctl", 32'(ctl_bits()), 32'h304);
        step();
        chk("sta_mem2_wrm", 32'(bus.wrM_contr), 1);
        step();
        chk("sta_mem3_wrm", 32'(bus.wrM_contr), 1);
        step();
        chk("sta_mem4_ctl", 32'(ctl_bits()), 32'h304);
        step();                                              // HALT
        chk("sta_halt_ctl", 32'(ctl_bits()), 32'h001);       // mem_err only
        chk("sta_halt_sel", 32'(sel_bits()), 32'hFF);
        for (int i = 0; i < 6; i++) begin
            step();
            lir_seen = lir_seen | bus.LIR;
        end
        chk("sta_halt_no_lir", 32'(lir_seen), 0);
        chk("sta_halt_err", 32'(bus.mem_err), 1);

        // Illegal 1000110; reset clears mem_err first
        rstIn        = 1'b1;
        bus.IW2Contr = 7'b1000110;
        step();
        chk("rst2_ctl", 32'(ctl_bits()), 32'h000);
        rstIn = 1'b0;
        step();                                              // FETCH
        chk("ill_fetch_lir", 32'(bus.LIR), 1);
        step();                                              // DECODE
        chk("ill_dec_ill", 32'(bus.illegal), 0);
        step();                                              // HALT
        chk("ill_halt_ctl", 32'(ctl_bits()), 32'h002);       // illegal only
        chk("ill_halt_sel", 32'(sel_bits()), 32'hFF);
        step();
        chk("ill_halt_hold", 32'(ctl_bits()), 32'h002);
        rstIn = 1'b1;
        step();
        chk("ill_rst_ctl", 32'(ctl_bits()), 32'h000);

        // la aborted by reset in MEM
        rstIn        = 1'b0;
        bus.IW2Contr = 7'b1000100;
        step();                                              // FETCH
        chk("ill_resume_lir", 32'(bus.LIR), 1);
        step();                                              // DECODE
        step();                                              // EXEC
        step();                                              // MEM
        chk("abort_mem1_rdm", 32'(bus.rdM), 1);
        step();                                              // MEM
        chk("abort_mem2_rdm", 32'(bus.rdM), 1);
        rstIn = 1'b1;
        step();
        chk("abort_rst_ctl", 32'(ctl_bits()), 32'h000);
        chk("abort_rst_sel", 32'(sel_bits()), 32'hFF);
        rstIn = 1'b0;
        step();
        chk("abort_fetch_ctl", 32'(ctl_bits()), 32'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
